ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter on the clkps2/dataps2 open-collector pair (e.g. keyboard LED/reset commands).
//  Counterpart of the existing device-to-host PS/2 receiver. Runs in the clk_chipset (50 MHz) domain.
//  Top level drives each pin low when its *_oe output is 1, and releases it (Z) otherwise.
//  busy tells the receiver to ignore the line while a command is in flight.
// PARAMETERS
//  CLK_FREQ_HZ      50_000_000  system clock frequency; all cycle counts derive from it
//  INHIBIT_US       100         time the clock line is held low before request-to-send
//  START_TIMEOUT_US 15000       max wait for the device's first falling clock edge
//  BYTE_TIMEOUT_US  2000        max time from the first edge until the line returns idle
//  FILTER_LEN       8           cycles an input must be stable before it is accepted
// PORTS
//  clk          in   1  system clock (clk_chipset)
//  reset_n      in   1  asynchronous active-low reset
//  tx_data      in   8  command byte
//  tx_valid     in   1  request; byte is accepted when tx_valid & tx_ready
//  tx_ready     out  1  1 only in IDLE
//  busy         out  1  1 in every state except IDLE
//  tx_done      out  1  1-cycle pulse: byte ACKed and line idle again
//  tx_error     out  1  1-cycle pulse: timeout or missing ACK
//  ps2_clk_in   in   1  raw clkps2 pin level (asynchronous)
//  ps2_data_in  in   1  raw dataps2 pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = drive clkps2 low
//  ps2_data_oe  out  1  1 = drive dataps2 low
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, both oe=0, tx_ready=1, busy=0, tx_done=0, tx_error=0.
//  Reset mid-frame releases both lines immediately.
//  Inputs: 2-FF synchroniser, then a FILTER_LEN stability filter.
//   Falling edge = filtered clock changes 1->0 (one-cycle strobe).
//  Frame: start(0), d0..d7 LSB first, odd parity (= ~^tx_data), stop(1), then ACK from device.
//  On accept, latch tx_data and compute parity.
//  States:
//   IDLE: oe=0/0; device edges are ignored. tx_valid & tx_ready -> INHIBIT.
//   INHIBIT: clk_oe=1 for INHIBIT_CYCLES = CLK_FREQ_HZ/1e6*INHIBIT_US (5000 at default).
//    On the last cycle set data_oe=1 (start bit) -> START.
//   START: clk_oe=0, data_oe=1, wait for falling edge.
//    Timer > START_TIMEOUT cycles -> ERR.
//    First edge: present d0 (data_oe = ~d0), edge count=1, start byte timer -> SHIFT.
//   SHIFT: on edges 1..9 present the next bit; the drive value updates the cycle after the edge strobe.
//    Bit order: d0..d7 on edges 1..8, parity after edge 8, stop (data_oe=0) after edge 9.
//    Edge 10 (stop bit sampled) -> ACK.
//   ACK: data_oe=0. On the next (11th) falling edge sample filtered data:
//    data=0 -> WAIT_IDLE; data=1 -> ERR.
//   WAIT_IDLE: wait until filtered clock=1 and data=1 -> pulse tx_done, go to IDLE.
//   ERR: both oe=0, pulse tx_error for 1 cycle -> IDLE.
//  Byte timer runs from SHIFT entry through WAIT_IDLE; > BYTE_TIMEOUT cycles in any of those states -> ERR.
//  Timer width: enough for max(START,BYTE) cycles (750_000 -> 20 bits); saturates, never wraps.
//  tx_done and tx_error are never asserted together.
//  tx_valid while busy is ignored; tx_data is only sampled at accept.
//  Edge counter 4 bits, cleared in IDLE; edges beyond 11 cannot occur (state has moved on).
//  Latency: tx_ready falls the cycle after accept; clk_oe rises the same cycle.
// TESTING
//  1 Send 0xED with a 10 kHz device model.
//    -> clk_oe high exactly 5000 cycles.
//    -> device samples 0,1,0,1,1,0,1,1,1,1,1 (start, data, parity 1, stop).
//    -> device ACKs; tx_done pulses once, tx_error stays 0.
//  2 Send 0x01 -> parity bit sampled 0; tx_done pulses.
//  3 No device clock after request-to-send.
//    -> tx_error pulses 750_000 cycles after START entry.
//    -> both oe=0, tx_ready=1.
//  4 Device leaves data high on the 11th edge -> tx_error pulse, no tx_done.
//  5 reset_n low mid-SHIFT (edge 4).
//    -> both oe=0 asynchronously; after release tx_ready=1.
//    -> next send of 0xF4 completes normally.
//  6 3-cycle low glitch on ps2_clk_in during SHIFT -> no bit advance; frame completes correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with request-to-send and ACK check
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int BYTE_TIMEOUT_US  = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int CYC_PER_US     = CLK_FREQ_HZ / 1_000_000;
    localparam int INHIBIT_CYCLES = CYC_PER_US * INHIBIT_US;
    localparam int START_CYCLES   = CYC_PER_US * START_TIMEOUT_US;
    localparam int BYTE_CYCLES    = CYC_PER_US * BYTE_TIMEOUT_US;
    localparam int TO_MAX         = (START_CYCLES > BYTE_CYCLES) ? START_CYCLES : BYTE_CYCLES;
    localparam int TIM_MAX        = (TO_MAX > INHIBIT_CYCLES) ? TO_MAX : INHIBIT_CYCLES;
    localparam int TW             = $clog2(TIM_MAX + 1);
    localparam int FW             = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_CYCLES - 1);
    localparam logic [TW-1:0] BYTE_LAST    = TW'(BYTE_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, ERR
    } state_t;

    state_t              state, state_next;
    logic   [1:0]        sync1, sync2;      // bit 0 = clock pin, bit 1 = data pin
    logic   [1:0]        filt;
    logic   [1:0][FW-1:0] fcnt;
    logic                filt_clk_q;
    logic                clk_fall;
    logic   [TW-1:0]     timer;
    logic                timer_clr;
    logic                byte_to;
    logic   [9:0]        sh;                // {stop, parity, d7..d0}, shifted out LSB first
    logic                drv;               // registered data_oe value while shifting
    logic   [3:0]        edge_cnt;

    // Two-flop synchroniser for both asynchronous pin levels (bus idles high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {ps2_data_in, ps2_clk_in};
            sync2 <= sync1;
        end
    end

    // Accept a new pin level only after it has been stable for FILTER_LEN cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 2'b11;
            fcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILTER_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed filtered clock for the one-cycle falling-edge strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) filt_clk_q <= 1'b1;
        else          filt_clk_q <= filt[0];
    end

    assign clk_fall = filt_clk_q & ~filt[0];
    assign byte_to  = (timer >= BYTE_LAST);

    // Phase timer: cleared in IDLE and on phase changes, saturates instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        timer <= '0;
        else if (state == IDLE || timer_clr) timer <= '0;
        else if (timer != '1)                timer <= timer + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; the byte timer runs from SHIFT entry until the line is idle again
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid && tx_ready) state_next = INHIBIT;
            end
            INHIBIT: begin
                if (timer == INHIBIT_LAST) begin
                    state_next = START;
                    timer_clr  = 1'b1;
                end
            end
            START: begin
                if (clk_fall) begin
                    state_next = SHIFT;
                    timer_clr  = 1'b1;
                end else if (timer >= START_LAST) begin
                    state_next = ERR;
                end
            end
            SHIFT: begin
                if (byte_to)                          state_next = ERR;
                else if (clk_fall && edge_cnt == 4'd9) state_next = ACK;
            end
            ACK: begin
                if (byte_to)       state_next = ERR;
                else if (clk_fall) state_next = filt[1] ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (byte_to)                 state_next = ERR;
                else if (filt[0] && filt[1]) state_next = IDLE;
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame shifter: latch byte and parity on accept, present one bit per device falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh       <= '0;
            drv      <= 1'b0;
            edge_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drv      <= 1'b0;
                    edge_cnt <= '0;
                    if (tx_valid) sh <= {1'b1, ~^tx_data, tx_data};
                end
                START: begin
                    if (clk_fall) begin
                        drv      <= ~sh[0];
                        sh       <= {1'b1, sh[9:1]};
                        edge_cnt <= 4'd1;
                    end
                end
                SHIFT: begin
                    if (clk_fall) begin
                        drv      <= ~sh[0];
                        sh       <= {1'b1, sh[9:1]};
                        edge_cnt <= edge_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_error    = (state == ERR);
    assign tx_done     = (state == WAIT_IDLE) && !byte_to && filt[0] && filt[1];
    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = ((state == INHIBIT) && (timer == INHIBIT_LAST)) ||
                         (state == START) ||
                         ((state == SHIFT) && drv);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int CLK_HZ   = 1_000_000;
    localparam int INH      = 100;      // INHIBIT cycles at CLK_HZ
    localparam int START_TO = 15000;    // start timeout cycles at CLK_HZ
    localparam int HALF     = 50;       // half period of the 10 kHz device clock

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int inh_run  = 0;
    int inh_last = 0;

    logic       bit_q[$];
    logic [1:0] res_q[$];   // {done, error}

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ     (CLK_HZ),
        .INHIBIT_US      (100),
        .START_TIMEOUT_US(15000),
        .BYTE_TIMEOUT_US (2000),
        .FILTER_LEN      (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic got);
        logic e;
        if (bit_q.size() != 0) e = bit_q.pop_front();
        else                   e = 1'bx;
        check(tag, {31'd0, got}, {31'd0, e});
    endtask

    // Result scoreboard and inhibit-length measurement
    always @(negedge clk) begin
        logic [1:0] er;
        if (ps2_clk_oe) inh_run++;
        else if (inh_run != 0) begin
            inh_last = inh_run;
            inh_run  = 0;
        end
        if (tx_done || tx_error) begin
            if (res_q.size() != 0) er = res_q.pop_front();
            else                   er = 2'bxx;
            check("result", {30'd0, tx_done, tx_error}, {30'd0, er});
            if (tx_done)  done_cnt++;
            if (tx_error) err_cnt++;
        end
    end

    task automatic send(input logic [7:0] b, input logic [1:0] exp_res);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
        bit_q.push_back(~^b);
        bit_q.push_back(1'b1);
        res_q.push_back(exp_res);
        @(negedge clk);
        check("accept_ready_low", {31'd0, tx_ready}, 32'd0);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        tx_data = ~b;                       // must be ignored while busy
        repeat (10) @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic device_frame(input bit ack, input int glitch_k, input int abort_k);
        int n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", {31'd0, (n < 1000)}, 32'd1);
        if (n >= 1000) return;
        repeat (20) @(negedge clk);
        expect_bit("bit_start", ps2_data_in);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == abort_k) return;
            dev_clk = 1'b1;
            if (k <= 10) expect_bit($sformatf("bit%0d", k), ps2_data_in);
            if (k == 10 && ack) dev_data = 1'b0;
            if (k == glitch_k) begin
                repeat (20) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 23) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (res_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_result_seen"}, res_q.size(), 32'd0);
        check({tag, "_bits_left"}, bit_q.size(), 32'd0);
        res_q.delete();
        bit_q.delete();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int n, t;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_done_err", {30'd0, tx_done, tx_error}, 32'd0);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);

        // 1: 0xED, normal ACK
        send(8'hED, 2'b10);
        device_frame(1'b1, 0, 0);
        wait_result("t1");
        check("t1_inhibit_len", inh_last, INH);

        // 2: 0x01, parity 0
        send(8'h01, 2'b10);
        device_frame(1'b1, 0, 0);
        wait_result("t2");

        // 3: no device clock -> start timeout
        send(8'hA5, 2'b01);
        bit_q.delete();
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        t = 0;
        while (!tx_error && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("t3_timeout_cycles", t, START_TO);
        check("t3_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("t3_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        @(negedge clk);
        check("t3_ready", {31'd0, tx_ready}, 32'd1);
        wait_result("t3");

        // 4: device withholds ACK
        send(8'h3C, 2'b01);
        device_frame(1'b0, 0, 0);
        wait_result("t4");

        // 5: asynchronous reset after the 4th device edge
        send(8'h55, 2'b10);
        device_frame(1'b1, 0, 4);
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        check("t5_data_oe_mid", {31'd0, ps2_data_oe}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("t5_clk_oe_async", {31'd0, ps2_clk_oe}, 32'd0);
        check("t5_data_oe_async", {31'd0, ps2_data_oe}, 32'd0);
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after_reset", {31'd0, tx_ready}, 32'd1);
        res_q.delete();
        bit_q.delete();
        repeat (40) @(negedge clk);
        send(8'hF4, 2'b10);
        device_frame(1'b1, 0, 0);
        wait_result("t5");

        // 6: 3-cycle clock glitch during the data bits
        send(8'h96, 2'b10);
        device_frame(1'b1, 5, 0);
        wait_result("t6");

        check("total_done", done_cnt, 32'd4);
        check("total_error", err_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
